regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-back scheduler and hazard scoreboard for the RV32E integer register file.
//  Arbitrates the file's single write port between EXU (ALU result) and LSU (load data) with valid/ready handshakes.
//  Tracks in-flight destination registers so decode can stall on RAW/WAW hazards.
//  Sits between issue/EXU/LSU and register_file (drives its wen_reg/rd/rin).
// PARAMETERS
//  REG_NUM  16  architectural registers tracked (RV32E); rd/rs indices >= REG_NUM are never busy
//  ADDR_W   5   register index width, matches register_file rs1/rs2/rd
//  DATA_W   32  write data width (`RegBus)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst          in   1       synchronous reset, active-low (rst==0 resets)
//  issue_valid  in   1       decode issues instr writing issue_rd
//  issue_rd     in   ADDR_W  destination of issued instr
//  issue_ready  out  1       issue accepted this cycle
//  rs1, rs2     in   ADDR_W  decode source indices for hazard query
//  rs1_busy     out  1       rs1 has uncommitted producer (comb)
//  rs2_busy     out  1       rs2 has uncommitted producer (comb)
//  exu_valid    in   1       EXU write-back request
//  exu_rd       in   ADDR_W  EXU destination
//  exu_data     in   DATA_W  EXU result
//  exu_ready    out  1       EXU request granted
//  lsu_valid/lsu_rd/lsu_data/lsu_ready: same as EXU, for load data
//  wen_reg      out  1       register_file write enable (registered)
//  rd           out  ADDR_W  register_file write index (registered)
//  rin          out  DATA_W  register_file write data (registered)
// BEHAVIOUR
//  Reset (rst==0 at posedge): busy[] all 0, wen_reg=0, rd=0, rin=0, rr pointer=EXU-first.
//   While rst==0: issue_ready=exu_ready=lsu_ready=0; a write-back granted the cycle before reset is dropped.
//  Scoreboard: busy[REG_NUM-1:0]; busy[0] hardwired 0.
//   rsX_busy = busy[rsX] (0 for index 0 or >= REG_NUM).
//   Issue: issue_ready = !busy[issue_rd] (WAW stall); on issue_valid&issue_ready with rd!=0, busy[issue_rd]<=1.
//   Clear: busy[rd]<=0 at the posedge where wen_reg==1 (same edge register_file commits).
//   Same-edge set and clear of one index: set wins.
//  Arbitration (2-way round robin):
//   Only one valid requester -> it gets ready.
//   Both valid -> the requester not granted last time wins.
//   Pointer updates only on a grant; it starts EXU-first after reset.
//   ready is combinational from valid and the pointer; at most one ready per cycle.
//   Write port always accepts, so throughput is 1 write/cycle.
//  Latency: handshake in cycle N -> wen_reg/rd/rin valid in cycle N+1 -> regfile and busy update at end of N+1.
//   Consumers see busy=0 and correct data in cycle N+2.
//   No bypass; decode must stall while rsX_busy.
//  Granted rd==0: handshake completes, wen_reg stays 0, no busy change.
//  No grant in a cycle: wen_reg<=0; rd and rin hold their previous values.
//  Requester must hold valid/rd/data stable until ready (not checked by this block).
// STRUCTURE
//  Shared defines.v: `RST_VAL (1'b0), `RegBus, `Reg0, `RegNum, plus new `WB_SRC_EXU/`WB_SRC_LSU ids.
//  Sub-module rr_arb2: 2-request round-robin arbiter (req[1:0], gnt[1:0], pointer flop). Reused for other 2-way shares.
//  Top: rr_arb2, write-port output flops, busy vector with set/clear logic, read muxes.
// TESTING
//  1 Reset: rst=0 for 2 cycles with all valids=1 -> all readies 0, wen_reg=0, busy all 0; first cycle after reset with both valid -> exu_ready=1.
//  2 Single EXU write: issue rd=5; exu rd=5 data=0xDEADBEEF -> next cycle wen_reg=1 rd=5 rin=0xDEADBEEF; rs1=5 busy until cycle N+2, then 0.
//  3 Contention: exu and lsu valid 4 cycles, distinct rd -> grants alternate EXU,LSU,EXU,LSU; wen_reg=1 every cycle.
//  4 WAW stall: busy[3]=1, issue rd=3 -> issue_ready=0 until the cycle after wen_reg=1 for rd=3.
//  5 Set/clear collision: wen_reg=1 rd=7 on the same edge as issue rd=7 -> busy[7]=1 afterwards.
//  6 rd=0 write: lsu rd=0 data=0x1 -> lsu_ready=1, wen_reg stays 0, rs1=0 busy=0; reset asserted mid-grant -> no write.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants for the register-file write-back controller: reset level,
// write-back source ids and default RV32E sizing.
package regfile_wb_ctrl_pkg;
  localparam logic RST_VAL      = 1'b0;
  localparam int   WB_SRC_EXU   = 0;
  localparam int   WB_SRC_LSU   = 1;
  localparam int   DEF_REG_NUM  = 16;
  localparam int   DEF_ADDR_W   = 5;
  localparam int   DEF_DATA_W   = 32;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-request round-robin arbiter; the priority flop names the requester that
// wins a tie and flips only when a grant is issued.
module rr_arb2
  import regfile_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_r;
  logic [1:0] gnt_s;

  // Grant decode: single requester wins outright, a tie goes to prio_r.
  always_comb begin
    gnt_s = 2'b00;
    if (rst == RST_VAL) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Priority pointer: after a grant the other requester is preferred.
  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      prio_r <= 1'b0;
    end else if (gnt_s[0]) begin
      prio_r <= 1'b1;
    end else if (gnt_s[1]) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back scheduler for the RV32E register file: arbitrates EXU/LSU onto the
// single write port and keeps the busy scoreboard used by decode for hazard stalls.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              exu_valid,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              wen_reg,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] rin
);

  logic [REG_NUM-1:0] busy_r;
  logic [REG_NUM-1:0] busy_next_s;
  logic [1:0]         req_s;
  logic [1:0]         gnt_s;
  logic [ADDR_W-1:0]  sel_rd_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               issue_ready_s;
  logic               issue_fire_s;
  logic               wen_r;
  logic [ADDR_W-1:0]  rd_r;
  logic [DATA_W-1:0]  rin_r;

  // Index 0 and indices beyond the tracked range never report busy.
  function automatic logic busy_at(input logic [REG_NUM-1:0] vec,
                                   input logic [ADDR_W-1:0] idx);
    busy_at = 1'b0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (idx == ADDR_W'(i)) busy_at = vec[i];
    end
  endfunction

  assign req_s[WB_SRC_EXU] = exu_valid;
  assign req_s[WB_SRC_LSU] = lsu_valid;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .gnt (gnt_s)
  );

  assign exu_ready     = gnt_s[WB_SRC_EXU];
  assign lsu_ready     = gnt_s[WB_SRC_LSU];
  assign issue_ready_s = (rst != RST_VAL) && !busy_at(busy_r, issue_rd);
  assign issue_fire_s  = issue_valid && issue_ready_s;
  assign issue_ready   = issue_ready_s;
  assign rs1_busy      = busy_at(busy_r, rs1);
  assign rs2_busy      = busy_at(busy_r, rs2);

  // Write-port source mux.
  always_comb begin
    sel_rd_s   = exu_rd;
    sel_data_s = exu_data;
    if (gnt_s[WB_SRC_LSU]) begin
      sel_rd_s   = lsu_rd;
      sel_data_s = lsu_data;
    end else begin
      sel_rd_s   = exu_rd;
      sel_data_s = exu_data;
    end
  end

  // Scoreboard next state: an issue to an index overrides its same-edge commit.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 1; i < REG_NUM; i++) begin
      if (issue_fire_s && (issue_rd == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (wen_r && (rd_r == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      busy_r <= {REG_NUM{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Write-port flops; a granted write to x0 completes without enabling the file.
  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      wen_r <= 1'b0;
      rd_r  <= {ADDR_W{1'b0}};
      rin_r <= {DATA_W{1'b0}};
    end else if (|gnt_s) begin
      wen_r <= (sel_rd_s != {ADDR_W{1'b0}});
      rd_r  <= sel_rd_s;
      rin_r <= sel_data_s;
    end else begin
      wen_r <= 1'b0;
      rd_r  <= rd_r;
      rin_r <= rin_r;
    end
  end

  assign wen_reg = wen_r;
  assign rd      = rd_r;
  assign rin     = rin_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, single write, contention, WAW stall,
// set/clear collision, x0 writes and reset during a request.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wen_reg;
  logic [4:0]  rd;
  logic [31:0] rin;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wen_reg(wen_reg), .rd(rd), .rin(rin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    exu_valid   = 1'b0;
    lsu_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd2;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    rs1 = 5'd2; rs2 = 5'd1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({issue_ready, exu_ready, lsu_ready} !== 3'b000) begin
        errors++; $display("FAIL reset_ready: got %b exp 000", {issue_ready, exu_ready, lsu_ready});
      end
      checks++;
      if (wen_reg !== 1'b0 || rd !== 5'd0 || rin !== 32'd0) begin
        errors++; $display("FAIL reset_wport: got wen=%b rd=%0d rin=%h exp 0/0/0", wen_reg, rd, rin);
      end
      checks++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy: got %b%b exp 00", rs1_busy, rs2_busy);
      end
    end
    issue_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_exu_first: got exu=%b lsu=%b exp 1/0", exu_ready, lsu_ready);
    end
    idle();
    tick();
  endtask

  task automatic test_single_exu();
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd21;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL single_issue_ready: got %b exp 1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL single_cycle_n: got ready=%b rs1b=%b rs2b=%b exp 1/1/0", exu_ready, rs1_busy, rs2_busy);
    end
    tick();
    exu_valid = 1'b0;
    #1;
    checks++;
    if (wen_reg !== 1'b1 || rd !== 5'd5 || rin !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_wport: got wen=%b rd=%0d rin=%h exp 1/5/deadbeef", wen_reg, rd, rin);
    end
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_n1: got %b exp 1", rs1_busy);
    end
    tick();
    checks++;
    if (rs1_busy !== 1'b0 || wen_reg !== 1'b0 || rin !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_n2: got busy=%b wen=%b rin=%h exp 0/0/deadbeef", rs1_busy, wen_reg, rin);
    end
  endtask

  task automatic test_contention();
    // EXU won last, so one LSU-only write puts EXU back at the front.
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h55;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
      errors++; $display("FAIL cont_prime: got lsu=%b exu=%b exp 1/0", lsu_ready, exu_ready);
    end
    tick();
    exu_valid = 1'b1; exu_rd = 5'd11; lsu_rd = 5'd12;
    for (int k = 0; k < 4; k++) begin
      exu_data = 32'h100 + 32'(k);
      lsu_data = 32'h200 + 32'(k);
      #1;
      checks++;
      if (exu_ready !== ((k % 2) == 0) || lsu_ready !== ((k % 2) == 1)) begin
        errors++; $display("FAIL cont_grant%0d: got exu=%b lsu=%b", k, exu_ready, lsu_ready);
      end
      tick();
      checks++;
      if (wen_reg !== 1'b1 || rd !== (((k % 2) == 0) ? 5'd11 : 5'd12) ||
          rin !== (((k % 2) == 0) ? 32'h100 + 32'(k) : 32'h200 + 32'(k))) begin
        errors++; $display("FAIL cont_write%0d: got wen=%b rd=%0d rin=%h", k, wen_reg, rd, rin);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_waw_stall();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (issue_ready !== 1'b0) begin
        errors++; $display("FAIL waw_stall%0d: got %b exp 0", c, issue_ready);
      end
      tick();
    end
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL waw_stall_grant: got %b exp 0", issue_ready);
    end
    tick();
    exu_valid = 1'b0;
    checks++;
    if (wen_reg !== 1'b1 || rd !== 5'd3 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL waw_commit: got wen=%b rd=%0d ready=%b exp 1/3/0", wen_reg, rd, issue_ready);
    end
    tick();
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL waw_release: got %b exp 1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    exu_valid = 1'b1;
    tick();
    exu_valid = 1'b0;
    tick();
    rs1 = 5'd3;
    #1;
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++; $display("FAIL waw_cleanup: got %b exp 0", rs1_busy);
    end
  endtask

  task automatic test_set_clear();
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
    tick();
    exu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    #1;
    checks++;
    if (wen_reg !== 1'b1 || rd !== 5'd7 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL collide_setup: got wen=%b rd=%0d ready=%b exp 1/7/1", wen_reg, rd, issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    tick();
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++; $display("FAIL collide_set_wins: got %b exp 1", rs1_busy);
    end
    exu_valid = 1'b1;
    tick();
    exu_valid = 1'b0;
    tick();
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++; $display("FAIL collide_clear: got %b exp 0", rs1_busy);
    end
  endtask

  task automatic test_rd0_and_reset();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_ready: got lsu=%b issue=%b exp 1/1", lsu_ready, issue_ready);
    end
    tick();
    lsu_valid = 1'b0; issue_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h2;
    checks++;
    if (wen_reg !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL rd0_no_write: got wen=%b busy=%b exp 0/0", wen_reg, rs1_busy);
    end
    tick();
    exu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: got %b exp 1", rs1_busy);
    end
    rst = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready: got %b exp 0", lsu_ready);
    end
    tick();
    checks++;
    if (wen_reg !== 1'b0 || rs1_busy !== 1'b0 || rin !== 32'd0) begin
      errors++; $display("FAIL rst_mid_state: got wen=%b busy=%b rin=%h exp 0/0/0", wen_reg, rs1_busy, rin);
    end
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd4;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ptr: got exu=%b lsu=%b exp 1/0", exu_ready, lsu_ready);
    end
    tick();
    idle();
    checks++;
    if (wen_reg !== 1'b1 || rd !== 5'd4) begin
      errors++; $display("FAIL rst_resume: got wen=%b rd=%0d exp 1/4", wen_reg, rd);
    end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_exu();
    test_contention();
    test_waw_stall();
    test_set_clear();
    test_rd0_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
